// File: rtl/mmio_timer_responder_if.sv
// Single-port synchronous memory bus shared by the CPU, the RAM and MMIO responders.
// The data lines are a resolved net: the initiator drives them for writes,
// the addressed responder drives them while a read is being returned.
interface mmio_timer_responder_if #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] addr;
   wire  [DATA_WIDTH-1:0] data;
   logic                  cs_input;
   logic                  we;
   logic                  oe;

   modport master (
      output addr,
      output cs_input,
      output we,
      output oe,
      inout  data
   );

   modport slave (
      input  addr,
      input  cs_input,
      input  we,
      input  oe,
      inout  data
   );
endinterface

// File: rtl/mmio_timer_responder.sv
// Memory-mapped countdown timer answering loads and stores in a 16-word window.
// Registers: CTRL(0) LOAD(1) COUNT(2) STATUS(3) SCRATCH(4); other offsets read 0.
// Reads have one cycle of registered latency and return the pre-edge register value.
module mmio_timer_responder #(
   parameter int                    ADDR_WIDTH = 28,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h0000F00
) (
   input  logic                   clk,
   input  logic                   rst,
   mmio_timer_responder_if.slave  bus,
   output logic                   irq,
   output logic [DATA_WIDTH-1:0]  count_out
);

   localparam logic [3:0] OFF_CTRL    = 4'd0;
   localparam logic [3:0] OFF_LOAD    = 4'd1;
   localparam logic [3:0] OFF_COUNT   = 4'd2;
   localparam logic [3:0] OFF_STATUS  = 4'd3;
   localparam logic [3:0] OFF_SCRATCH = 4'd4;

   localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   // CTRL bit positions
   localparam int EN_BIT     = 0;
   localparam int RELOAD_BIT = 1;
   localparam int IRQEN_BIT  = 2;

   logic                  hit;
   logic                  wr_hit;
   logic                  rd_hit;
   logic [3:0]            off;
   logic [DATA_WIDTH-1:0] wdata;

   logic [2:0]            ctrl_q,    ctrl_d;
   logic [DATA_WIDTH-1:0] load_q,    load_d;
   logic [DATA_WIDTH-1:0] count_q,   count_d;
   logic                  expired_q, expired_d;
   logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
   logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
   logic                  hit_q;
   logic                  expiring;

   assign hit    = (bus.addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
   assign off    = bus.addr[3:0];
   assign wdata  = bus.data;
   assign wr_hit = bus.cs_input &  bus.we & hit;
   assign rd_hit = bus.cs_input & ~bus.we & hit;

   // An enabled timer sitting at zero expires on this edge.
   assign expiring = ctrl_q[EN_BIT] && (count_q == '0);

   // Read mux: selects the current (pre-update) value of the addressed register.
   always_comb begin
      rdata_d = '0;
      case (off)
         OFF_CTRL:    rdata_d[2:0] = ctrl_q;
         OFF_LOAD:    rdata_d      = load_q;
         OFF_COUNT:   rdata_d      = count_q;
         OFF_STATUS:  rdata_d[0]   = expired_q;
         OFF_SCRATCH: rdata_d      = scratch_q;
         default:     rdata_d      = '0;
      endcase
   end

   // Next-state: timer action first, then bus writes override where they collide.
   always_comb begin
      ctrl_d    = ctrl_q;
      load_d    = load_q;
      count_d   = count_q;
      expired_d = expired_q;
      scratch_d = scratch_q;

      if (ctrl_q[EN_BIT]) begin
         if (count_q != '0) begin
            count_d = count_q - ONE;
         end else begin
            expired_d = 1'b1;
            if (ctrl_q[RELOAD_BIT]) begin
               count_d = load_q;          // old LOAD even if LOAD is written now
            end else begin
               ctrl_d[EN_BIT] = 1'b0;     // one-shot stops itself
            end
         end
      end

      if (wr_hit) begin
         case (off)
            OFF_CTRL:    ctrl_d    = wdata[2:0];
            OFF_LOAD:    load_d    = wdata;
            OFF_COUNT:   count_d   = wdata;
            // write-1-clear, but a simultaneous expiry keeps the flag set
            OFF_STATUS:  if (wdata[0]) expired_d = expiring;
            OFF_SCRATCH: scratch_d = wdata;
            default:     ;
         endcase
      end
   end

   // Register update; reset overrides any bus write or expiry in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q    <= '0;
         load_q    <= '0;
         count_q   <= '0;
         expired_q <= 1'b0;
         scratch_q <= '0;
         rdata_q   <= '0;
         hit_q     <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         count_q   <= count_d;
         expired_q <= expired_d;
         scratch_q <= scratch_d;
         hit_q     <= rd_hit;
         if (rd_hit) begin
            rdata_q <= rdata_d;
         end
      end
   end

   // Drive the shared bus only while the initiator is still reading from us.
   assign bus.data = (bus.cs_input && bus.oe && !bus.we && hit_q) ? rdata_q : 'z;

   assign irq       = expired_q & ctrl_q[IRQEN_BIT];
   assign count_out = count_q;

endmodule
